interp_block_sequencer: RTL and testbench
=========================================

Name: interp_block_sequencer

Overview:
- Sequences one 8x8 HEVC sub-pixel interpolation block through the existing datapath.
- Accepts 15 reference rows (15 pixels x 8 bits = 120 bits each) from upstream and drives the input shift register's load_L.
- Issues 40 filter operations (8 rows x 5 sub-pel phases).
- Steps the output filler's load_L and sel in lock-step with the filter pipeline, then holds a block-done handshake until downstream accepts.

Parameters:
- IN_ROWS, 15, reference rows loaded per block (8 + 7 filter taps).
- OUT_WORDS, 40, 64-bit result words pushed into the output filler per block.
- FILT_LAT, 2, filter pipeline latency in clock cycles from filt_en to valid result (1..7).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse: begin a block; sampled only in IDLE.
- frac_x  in  2  horizontal quarter-pel phase; latched on accepted start.
- frac_y  in  2  vertical quarter-pel phase; latched on accepted start.
- row_valid  in  1  upstream reference row valid.
- row_ready  out  1  sequencer accepts a row this cycle.
- in_load_L  out  1  active-low load to the input shift register.
- filt_en  out  1  issue one filter op this cycle.
- filt_idx  out  6  index of the issued op, 0..39.
- frac_x_q  out  2  latched horizontal phase.
- frac_y_q  out  2  latched vertical phase.
- out_load_L  out  1  active-low load to the output filler.
- sel  out  8  output filler slot for the current result, 0..39.
- busy  out  1  high in every state except IDLE.
- blk_valid  out  1  block complete; output filler contents are stable.
- blk_ready  in  1  downstream consumed the block.

Behaviour:
Reset values (async, on reset high):
- State = IDLE; all counters = 0.
- row_ready = 0, in_load_L = 1, filt_en = 0, filt_idx = 0, out_load_L = 1, sel = 0.
- busy = 0, blk_valid = 0, frac_x_q = frac_y_q = 0.
- Reset asserted mid-block aborts the block immediately. No partial blk_valid is ever produced.

State machine (IDLE, FILL, FILTER, DRAIN, DONE):
- IDLE: start=1 latches frac_x/frac_y, clears row_cnt and op_cnt, then goes to FILL. start in any other state is ignored.
- FILL:
  - row_ready = 1 (registered; asserted from the first FILL cycle).
  - Handshake = row_valid & row_ready; each handshake increments row_cnt.
  - in_load_L = ~(row_valid & row_ready). This is the only combinational output. The shift register samples it at the negedge inside the handshake cycle, so upstream holds its row data stable for the whole handshake cycle.
  - On the 15th handshake (row_cnt = 14 -> 15), go to FILTER. row_ready drops in the same posedge.
  - A row_valid low cycle inserts a bubble with no load.
- FILTER:
  - filt_en = 1 and filt_idx = op_cnt on every cycle; op_cnt increments.
  - After op 39 is issued, go to DRAIN.
  - No stalls: exactly 40 consecutive cycles.
- Result pipeline:
  - A FILT_LAT-deep shift register carries {valid, idx}.
  - When its tail is valid: out_load_L = 0 and sel = tail idx (both registered), so the output filler shifts at that cycle's negedge.
  - Every result produces exactly one out_load_L low cycle. The sel sequence is 0, 1, ..., 39, strictly in order.
- DRAIN: wait until the pipeline is empty (40 out_load_L pulses counted), then go to DONE.
- DONE:
  - blk_valid = 1; it holds until blk_ready = 1 at a posedge, then IDLE.
  - blk_ready and start both high in DONE: return to IDLE only; start is not accepted that cycle.
  - blk_ready while not in DONE is ignored.

Widths and arithmetic:
- row_cnt is 4 bits and op_cnt is 6 bits, both saturate-free: their range is bounded by the FSM.
- The out_load_L pulse counter is 6 bits.

Latency (start to blk_valid):
- Without upstream bubbles: 1 + 15 + 40 + FILT_LAT + 1 cycles.
- For FILT_LAT = 2: 59 cycles.

Full-pel case (frac_x = frac_y = 0): the same sequence runs unchanged. The filter handles bypass.

Decomposition:
- Shared package interp_pkg holds:
  - state encoding enum (IDLE=0, FILL=1, FILTER=2, DRAIN=3, DONE=4);
  - constants IN_ROWS = 15, OUT_WORDS = 40, PIX_W = 8, ROW_W = 120, WORD_W = 64.
- One natural sub-module: interp_result_pipe, the FILT_LAT-deep {valid, idx} delay line that produces out_load_L and sel.

Test Plan:
- Reset mid-FILTER (op_cnt = 20) -> next cycle: busy = 0, filt_en = 0, out_load_L = 1, sel = 0. A following start completes normally.
- start with frac_x = 2, frac_y = 1, then 15 back-to-back rows -> exactly 15 in_load_L low cycles; FILTER entered; filt_idx 0..39 on consecutive cycles; out_load_L low 40 cycles with sel 0..39 starting FILT_LAT cycles after first filt_en; blk_valid at cycle 59; frac_x_q = 2, frac_y_q = 1.
- row_valid toggled 1-0-1-0 during FILL -> in_load_L low only on handshake cycles; FILTER entered exactly after the 15th handshake; total latency 59 + 14 bubbles.
- blk_ready held low 10 cycles in DONE -> blk_valid stays 1, sel/out_load_L static; blk_ready = 1 -> IDLE next cycle, busy = 0.
- start pulsed during FILL and during DONE together with blk_ready -> ignored; no restart, frac_x_q unchanged; next start in IDLE accepted.
- FILT_LAT = 5 build -> first out_load_L low 5 cycles after first filt_en; blk_valid at cycle 62.

Source files
------------

// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared definitions for the 8x8 HEVC sub-pixel interpolation block sequencer.
// Holds the FSM state encoding and the block geometry constants used by the
// sequencer and its result pipeline.
// -----------------------------------------------------------------------------
package interp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_FILTER = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int IN_ROWS   = 15;   // 8 output rows + 7 filter taps
  localparam int OUT_WORDS = 40;   // 8 rows x 5 sub-pel phases
  localparam int PIX_W     = 8;
  localparam int ROW_W     = IN_ROWS * PIX_W;  // 120-bit reference row
  localparam int WORD_W    = 64;
  localparam int IDX_W     = 6;    // op / result index, 0..39

endpackage

// File: rtl/interp_result_pipe.sv
// -----------------------------------------------------------------------------
// interp_result_pipe
// FILT_LAT-deep {valid, idx} delay line that mirrors the filter pipeline.
// The tail stage drives the output filler directly from flops, so a result
// issued in cycle N appears as out_load_L low in cycle N + FILT_LAT.
//
// Ports:
//   clock, reset  - system clock, async active-high reset
//   issue_en      - a filter op is issued this cycle
//   issue_idx     - index of the issued op
//   out_load_L    - active-low load strobe to the output filler
//   sel           - output filler slot of the current result
// -----------------------------------------------------------------------------
module interp_result_pipe
  import interp_pkg::*;
#(
  parameter int unsigned FILT_LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_en,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             out_load_L,
  output logic [7:0]       sel
);

  logic [FILT_LAT-1:0] v_q;
  logic [IDX_W-1:0]    idx_q [FILT_LAT];

  // Index stages only advance alongside a valid entry, so once the pipe
  // drains sel keeps showing the last slot written and stays static.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < FILT_LAT; k++) idx_q[k] <= '0;
    end else begin
      v_q <= FILT_LAT'({v_q, issue_en});
      if (issue_en) idx_q[0] <= issue_idx;
      for (int k = 1; k < FILT_LAT; k++) begin
        if (v_q[k-1]) idx_q[k] <= idx_q[k-1];
      end
    end
  end

  assign out_load_L = ~v_q[FILT_LAT-1];
  assign sel        = {2'b00, idx_q[FILT_LAT-1]};

endmodule

// File: rtl/interp_block_sequencer.sv
// -----------------------------------------------------------------------------
// interp_block_sequencer
// Sequences one 8x8 sub-pixel interpolation block: loads 15 reference rows
// into the input shift register, issues 40 filter ops back to back, steps the
// output filler as results emerge, then holds blk_valid until downstream
// accepts the block.
//
// Handshakes (valid/ready): a row transfers in any cycle where row_valid and
// row_ready are both high at the posedge; upstream keeps the row data stable
// for that whole cycle. A block transfers in the cycle where blk_valid and
// blk_ready are both high; blk_ready is ignored outside DONE.
//
// Ports:
//   clock, reset          - system clock, async active-high reset
//   start                 - begin a block (sampled in IDLE only)
//   frac_x, frac_y        - quarter-pel phases, latched on accepted start
//   row_valid / row_ready - reference row handshake
//   in_load_L             - active-low load to input shift register (comb)
//   filt_en, filt_idx     - filter op issue strobe and op index 0..39
//   frac_x_q, frac_y_q    - latched phases
//   out_load_L, sel       - output filler load strobe and slot 0..39
//   busy                  - high in every state except IDLE
//   blk_valid / blk_ready - block complete handshake
//   dbg_state             - current FSM state
// -----------------------------------------------------------------------------
module interp_block_sequencer
  import interp_pkg::*;
#(
  parameter int unsigned FILT_LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       frac_x,
  input  logic [1:0]       frac_y,
  input  logic             row_valid,
  output logic             row_ready,
  output logic             in_load_L,
  output logic             filt_en,
  output logic [IDX_W-1:0] filt_idx,
  output logic [1:0]       frac_x_q,
  output logic [1:0]       frac_y_q,
  output logic             out_load_L,
  output logic [7:0]       sel,
  output logic             busy,
  output logic             blk_valid,
  input  logic             blk_ready,
  output state_t           dbg_state
);

  state_t           state;
  logic [3:0]       row_cnt;
  logic [IDX_W-1:0] op_cnt;
  logic [5:0]       pulse_cnt;
  logic             row_hs;

  assign row_hs    = row_valid & row_ready;
  // The shift register samples this at the negedge inside the handshake cycle.
  assign in_load_L = ~row_hs;
  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      op_cnt    <= '0;
      row_ready <= 1'b0;
      filt_en   <= 1'b0;
      filt_idx  <= '0;
      frac_x_q  <= '0;
      frac_y_q  <= '0;
      busy      <= 1'b0;
      blk_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            frac_x_q  <= frac_x;
            frac_y_q  <= frac_y;
            row_cnt   <= '0;
            op_cnt    <= '0;
            row_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (row_hs) begin
            row_cnt <= row_cnt + 4'd1;
            if (row_cnt == 4'(IN_ROWS - 1)) begin
              // Issue op 0 on the very first FILTER cycle.
              row_ready <= 1'b0;
              filt_en   <= 1'b1;
              filt_idx  <= op_cnt;
              op_cnt    <= op_cnt + 6'd1;
              state     <= ST_FILTER;
            end
          end
        end
        ST_FILTER: begin
          // op_cnt runs one ahead of filt_idx: reaching OUT_WORDS means op 39
          // is on the bus this cycle.
          if (op_cnt == 6'(OUT_WORDS)) begin
            filt_en <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            filt_idx <= op_cnt;
            op_cnt   <= op_cnt + 6'd1;
          end
        end
        ST_DRAIN: begin
          if (pulse_cnt == 6'(OUT_WORDS)) begin
            blk_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A coincident start is deliberately not taken here.
          if (blk_ready) begin
            blk_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counts output filler loads so DRAIN knows when the pipe is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      pulse_cnt <= '0;
    end else if (!out_load_L) begin
      pulse_cnt <= pulse_cnt + 6'd1;
    end
  end

  interp_result_pipe #(
    .FILT_LAT (FILT_LAT)
  ) u_result_pipe (
    .clock      (clock),
    .reset      (reset),
    .issue_en   (filt_en),
    .issue_idx  (filt_idx),
    .out_load_L (out_load_L),
    .sel        (sel)
  );

endmodule

// File: tb/tb_interp_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interp_block_sequencer
// Drives two sequencers (FILT_LAT = 2 and FILT_LAT = 5) from shared stimulus.
// Cycle numbering: start is driven in cycle 0; cycle N is the interval after
// the N-th posedge that follows, so the start-sampling edge opens cycle 1.
// -----------------------------------------------------------------------------
module tb_interp_block_sequencer;
  import interp_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       start = 1'b0;
  logic [1:0] frac_x = 2'd0;
  logic [1:0] frac_y = 2'd0;
  logic       row_valid = 1'b0;
  logic       blk_ready = 1'b0;

  logic       row_ready_a, in_load_L_a, filt_en_a, out_load_L_a, busy_a, blk_valid_a;
  logic [5:0] filt_idx_a;
  logic [1:0] frac_x_q_a, frac_y_q_a;
  logic [7:0] sel_a;
  state_t     state_a;

  logic       row_ready_b, in_load_L_b, filt_en_b, out_load_L_b, busy_b, blk_valid_b;
  logic [5:0] filt_idx_b;
  logic [1:0] frac_x_q_b, frac_y_q_b;
  logic [7:0] sel_b;
  state_t     state_b;

  interp_block_sequencer #(.FILT_LAT(2)) dut_a (
    .clock(clock), .reset(reset), .start(start), .frac_x(frac_x), .frac_y(frac_y),
    .row_valid(row_valid), .row_ready(row_ready_a), .in_load_L(in_load_L_a),
    .filt_en(filt_en_a), .filt_idx(filt_idx_a), .frac_x_q(frac_x_q_a), .frac_y_q(frac_y_q_a),
    .out_load_L(out_load_L_a), .sel(sel_a), .busy(busy_a), .blk_valid(blk_valid_a),
    .blk_ready(blk_ready), .dbg_state(state_a)
  );

  interp_block_sequencer #(.FILT_LAT(5)) dut_b (
    .clock(clock), .reset(reset), .start(start), .frac_x(frac_x), .frac_y(frac_y),
    .row_valid(row_valid), .row_ready(row_ready_b), .in_load_L(in_load_L_b),
    .filt_en(filt_en_b), .filt_idx(filt_idx_b), .frac_x_q(frac_x_q_b), .frac_y_q(frac_y_q_b),
    .out_load_L(out_load_L_b), .sel(sel_b), .busy(busy_b), .blk_valid(blk_valid_b),
    .blk_ready(blk_ready), .dbg_state(state_b)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp5_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] fx;
    logic [1:0] fy;
    bit         bubbles;        // row_valid 1-0-1-0 during FILL
    bit         glitch;         // start + blk_ready pulsed mid-FILL
    int         hold;           // cycles blk_ready stays low in DONE
    bit         start_in_done;  // start high together with blk_ready
    int         lat_a;          // cycle of first blk_valid, FILT_LAT = 2
    int         lat_b;          // cycle of first blk_valid, FILT_LAT = 5
  } vec_t;

  vec_t tbl[5];

  // ---------------------------------------------------------------- drivers
  task automatic run_block(input vec_t v);
    int cyc = 0;
    int rows = 0;
    int loads = 0;
    int spurious = 0;
    int last_hs = -1;
    int first_filt = -1;
    int filt_cnt = 0;
    int first_out_a = -1;
    int first_out_b = -1;
    int outs_a = 0;
    int outs_b = 0;
    int done_a = -1;
    int done_b = -1;

    exp_q.delete();
    exp5_q.delete();
    for (int i = 0; i < OUT_WORDS; i++) begin
      exp_q.push_back(8'(i));
      exp5_q.push_back(8'(i));
    end

    frac_x = v.fx;
    frac_y = v.fy;
    start  = 1'b1;
    while ((done_a < 0 || done_b < 0) && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      start     = 1'b0;
      blk_ready = 1'b0;
      frac_x    = v.fx;
      if (v.glitch && cyc == 5) begin
        start     = 1'b1;
        blk_ready = 1'b1;
        frac_x    = ~v.fx;
      end
      row_valid = (rows < IN_ROWS) && (!v.bubbles || (cyc % 2 == 1));
      #1;
      if (!in_load_L_a) loads++;
      if (!in_load_L_a && !row_valid) spurious++;
      if (row_valid && row_ready_a) begin
        rows++;
        if (rows == IN_ROWS) last_hs = cyc;
      end
      if (filt_en_a) begin
        if (first_filt < 0) first_filt = cyc;
        check("filt_idx", int'(filt_idx_a), cyc - first_filt);
        filt_cnt++;
      end
      if (!out_load_L_a) begin
        if (first_out_a < 0) first_out_a = cyc;
        outs_a++;
        if (exp_q.size() > 0) check("sel_lat2", int'(sel_a), int'(exp_q.pop_front()));
        else check("extra_load_lat2", outs_a, OUT_WORDS);
      end
      if (!out_load_L_b) begin
        if (first_out_b < 0) first_out_b = cyc;
        outs_b++;
        if (exp5_q.size() > 0) check("sel_lat5", int'(sel_b), int'(exp5_q.pop_front()));
        else check("extra_load_lat5", outs_b, OUT_WORDS);
      end
      if (blk_valid_a && done_a < 0) done_a = cyc;
      if (blk_valid_b && done_b < 0) done_b = cyc;
    end
    start     = 1'b0;
    blk_ready = 1'b0;
    row_valid = 1'b0;
    frac_x    = v.fx;

    check("latency_lat2", done_a, v.lat_a);
    check("latency_lat5", done_b, v.lat_b);
    check("in_loads", loads, IN_ROWS);
    check("spurious_in_load", spurious, 0);
    check("filter_entry", first_filt, last_hs + 1);
    check("filt_ops", filt_cnt, OUT_WORDS);
    check("out_loads_lat2", outs_a, OUT_WORDS);
    check("out_loads_lat5", outs_b, OUT_WORDS);
    check("first_out_lat2", first_out_a - first_filt, 2);
    check("first_out_lat5", first_out_b - first_filt, 5);
    check("frac_x_q", int'(frac_x_q_a), int'(v.fx));
    check("frac_y_q", int'(frac_y_q_a), int'(v.fy));
    check("frac_x_q_lat5", int'(frac_x_q_b), int'(v.fx));
    check("busy_in_done", int'(busy_a), 1);

    for (int h = 0; h < v.hold; h++) begin
      @(posedge clock);
      #1;
      check("hold_blk_valid", int'(blk_valid_a), 1);
      check("hold_out_load_L", int'(out_load_L_a), 1);
      check("hold_sel", int'(sel_a), OUT_WORDS - 1);
    end

    blk_ready = 1'b1;
    if (v.start_in_done) begin
      start  = 1'b1;
      frac_x = ~v.fx;
    end
    @(posedge clock);
    #1;
    blk_ready = 1'b0;
    start     = 1'b0;
    frac_x    = v.fx;
    check("release_busy", int'(busy_a), 0);
    check("release_blk_valid", int'(blk_valid_a), 0);
    check("release_busy_lat5", int'(busy_b), 0);
    check("release_blk_valid_lat5", int'(blk_valid_b), 0);
    check("release_frac_x_q", int'(frac_x_q_a), int'(v.fx));
    @(posedge clock);
    #1;
    check("idle_after_release", int'(state_a), int'(ST_IDLE));
    check("scoreboard_empty", exp_q.size() + exp5_q.size(), 0);
  endtask

  task automatic reset_mid_filter();
    bit found = 1'b0;
    frac_x = 2'd1;
    frac_y = 2'd2;
    start  = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clock);
      #1;
      start     = 1'b0;
      row_valid = 1'b1;
      #1;
      if (filt_en_a && filt_idx_a == 6'd20) found = 1'b1;
    end
    row_valid = 1'b0;
    check("reach_op20", int'(found), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", int'(busy_a), 0);
    check("abort_filt_en", int'(filt_en_a), 0);
    check("abort_out_load_L", int'(out_load_L_a), 1);
    check("abort_sel", int'(sel_a), 0);
    check("abort_blk_valid", int'(blk_valid_a), 0);
    check("abort_state", int'(state_a), int'(ST_IDLE));
    check("abort_busy_lat5", int'(busy_b), 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    // fx  fy  bub glitch hold sid lat2 lat5
    tbl[0] = '{2'd2, 2'd1, 1'b0, 1'b0, 0,  1'b0, 59, 62};
    tbl[1] = '{2'd0, 2'd0, 1'b1, 1'b0, 0,  1'b0, 73, 76};
    tbl[2] = '{2'd1, 2'd3, 1'b0, 1'b0, 10, 1'b0, 59, 62};
    tbl[3] = '{2'd3, 2'd2, 1'b0, 1'b1, 0,  1'b1, 59, 62};
    tbl[4] = '{2'd2, 2'd2, 1'b0, 1'b0, 0,  1'b0, 59, 62};

    #12;
    check("rst_row_ready", int'(row_ready_a), 0);
    check("rst_in_load_L", int'(in_load_L_a), 1);
    check("rst_filt_en", int'(filt_en_a), 0);
    check("rst_filt_idx", int'(filt_idx_a), 0);
    check("rst_out_load_L", int'(out_load_L_a), 1);
    check("rst_sel", int'(sel_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_blk_valid", int'(blk_valid_a), 0);
    check("rst_frac_q", int'({frac_x_q_a, frac_y_q_a}), 0);
    check("rst_state", int'(state_a), int'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #2;

    reset_mid_filter();
    @(posedge clock);
    #2;

    for (int t = 0; t < 5; t++) run_block(tbl[t]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
